// File: rtl/df_prof_pkg.sv
// Shared types and helpers for the dataflow process profiler.
// Optional feature macro: DF_PROFILER_IDLE_GAP_EN adds a trailing idle_gap
// field to every record.
package df_prof_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        BLOCKED = 2'd2
    } state_e;

    localparam int TS_W_DEF  = 32;
    localparam int CNT_W_DEF = 16;

`ifdef DF_PROFILER_IDLE_GAP_EN
    localparam int N_CNT = 5;
`else
    localparam int N_CNT = 4;
`endif

    // Field layout of rec_data at the default widths; start_ts sits in the MSBs.
    typedef struct packed {
        logic [TS_W_DEF-1:0]  start_ts;
        logic [CNT_W_DEF-1:0] latency;
        logic [CNT_W_DEF-1:0] cin_cnt;
        logic [CNT_W_DEF-1:0] cout_cnt;
        logic [CNT_W_DEF-1:0] blocked_cnt;
`ifdef DF_PROFILER_IDLE_GAP_EN
        logic [CNT_W_DEF-1:0] idle_gap;
`endif
    } rec_t;

    // Total record width for a given timestamp/counter width.
    function automatic int rec_w(input int ts_w, input int cnt_w);
        return ts_w + N_CNT * cnt_w;
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (val >= max_v) ? max_v : val + 32'd1;
    endfunction

endpackage

// File: rtl/df_process_profiler_if.sv
// Handshake, channel-flag and record-readout bundle of the process profiler.
interface df_process_profiler_if #(
    parameter int TS_W  = 32,
    parameter int CNT_W = 16
);
    import df_prof_pkg::*;

    localparam int REC_W = rec_w(TS_W, CNT_W);

    logic             enable;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             cin_stall;
    logic             cout_stall;
    logic             rec_valid;
    logic             rec_ready;
    logic [REC_W-1:0] rec_data;
    logic [31:0]      start_cnt;
    logic [15:0]      drop_cnt;
    logic             busy;

    // Environment side: drives the monitored handshake and drains records.
    modport master (
        output enable, ap_start, ap_ready, ap_done, ap_continue,
        output cin_stall, cout_stall, rec_ready,
        input  rec_valid, rec_data, start_cnt, drop_cnt, busy
    );

    // Profiler side.
    modport slave (
        input  enable, ap_start, ap_ready, ap_done, ap_continue,
        input  cin_stall, cout_stall, rec_ready,
        output rec_valid, rec_data, start_cnt, drop_cnt, busy
    );

endinterface

// File: rtl/df_prof_fifo.sv
// Synchronous first-word-fall-through FIFO holding completed profiler records.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module df_prof_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         empty;
    logic         rd_en;
    logic         wr_en;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign valid = !empty;
    assign data  = empty ? '0 : mem[rd_q[AW-1:0]];

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_d = wr_q;
        rd_d = rd_q;
        if (wr_en) wr_d = wr_q + (AW+1)'(1);
        if (rd_en) rd_d = rd_q + (AW+1)'(1);
    end

    // Pointer registers.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Record storage write port.
    always_ff @(posedge clock) begin
        // NOTE: storage is deliberately not reset; the pointers define which entries are valid.
        if (wr_en) mem[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/df_process_profiler.sv
// Per-process transaction profiler: watches one ap_* handshake plus channel
// stall flags and condenses each transaction into a buffered record
// {start_ts, latency, cin_cnt, cout_cnt, blocked_cnt}.
// Optional feature macro: DF_PROFILER_IDLE_GAP_EN appends an idle_gap field.
module df_process_profiler
    import df_prof_pkg::*;
#(
    parameter int TS_W  = 32,
    parameter int CNT_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    df_process_profiler_if.slave  bus
);
    localparam int REC_W = rec_w(TS_W, CNT_W);

    state_e             state_q, state_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [TS_W-1:0]    start_ts_q, start_ts_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   cin_q, cin_d;
    logic [CNT_W-1:0]   cout_q, cout_d;
    logic [CNT_W-1:0]   blk_q, blk_d;
    logic [31:0]        start_cnt_q, start_cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
`ifdef DF_PROFILER_IDLE_GAP_EN
    logic [CNT_W-1:0]   gap_q, gap_d;
`endif

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_valid;
    logic [REC_W-1:0]   fifo_data;
    logic [REC_W-1:0]   rec_word;
    logic               start_evt;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(32'(v), CNT_W));
    endfunction

    assign start_evt = bus.enable && bus.ap_start;
    assign pop       = fifo_valid && bus.rec_ready;

    // Transaction FSM and per-transaction counters; the record is built from
    // the next-state counter values so the completing cycle is included.
    always_comb begin
        state_d    = state_q;
        start_ts_d = start_ts_q;
        lat_d      = lat_q;
        cin_d      = cin_q;
        cout_d     = cout_q;
        blk_d      = blk_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_evt) begin
                    start_ts_d = ts_q;
                    lat_d      = CNT_W'(1);
                    cin_d      = CNT_W'(bus.cin_stall);
                    cout_d     = CNT_W'(bus.cout_stall);
                    blk_d      = '0;
                    if (bus.ap_done && bus.ap_continue) push    = 1'b1;
                    else if (bus.ap_done)               state_d = BLOCKED;
                    else                                state_d = RUN;
                end
            end
            RUN: begin
                lat_d = cnt_inc(lat_q);
                if (bus.cin_stall)  cin_d  = cnt_inc(cin_q);
                if (bus.cout_stall) cout_d = cnt_inc(cout_q);
                if (bus.ap_done) begin
                    if (bus.ap_continue) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = BLOCKED;
                    end
                end
            end
            BLOCKED: begin
                lat_d = cnt_inc(lat_q);
                blk_d = cnt_inc(blk_q);
                if (bus.ap_continue) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef DF_PROFILER_IDLE_GAP_EN
        rec_word = {start_ts_d, lat_d, cin_d, cout_d, blk_d, gap_q};
`else
        rec_word = {start_ts_d, lat_d, cin_d, cout_d, blk_d};
`endif
    end

    // Free-running timestamp, start-event counter and drop counter.
    always_comb begin
        ts_d        = ts_q + TS_W'(1);
        start_cnt_d = start_cnt_q + 32'(bus.ap_start && bus.ap_ready);
        drop_cnt_d  = drop_cnt_q;
        if (push && fifo_full && !pop) drop_cnt_d = 16'(sat_inc(32'(drop_cnt_q), 16));
    end

`ifdef DF_PROFILER_IDLE_GAP_EN
    // Idle cycles since the previous record completed; frozen while a transaction runs.
    always_comb begin
        gap_d = gap_q;
        if (push)                                gap_d = '0;
        else if (state_q == IDLE && !start_evt)  gap_d = cnt_inc(gap_q);
    end

    // Idle-gap register.
    always_ff @(posedge clock) begin
        if (reset) gap_q <= '0;
        else       gap_q <= gap_d;
    end
`endif

    // State and counter registers; reset drops any partial transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ts_q        <= '0;
            start_ts_q  <= '0;
            lat_q       <= '0;
            cin_q       <= '0;
            cout_q      <= '0;
            blk_q       <= '0;
            start_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            start_ts_q  <= start_ts_d;
            lat_q       <= lat_d;
            cin_q       <= cin_d;
            cout_q      <= cout_d;
            blk_q       <= blk_d;
            start_cnt_q <= start_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    df_prof_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (rec_word),
        .pop       (pop),
        .valid     (fifo_valid),
        .data      (fifo_data),
        .full      (fifo_full)
    );

    assign bus.rec_valid = fifo_valid;
    assign bus.rec_data  = fifo_data;
    assign bus.start_cnt = start_cnt_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_df_process_profiler.sv
// Directed bench for df_process_profiler: a default-width instance plus a
// narrow instance (TS_W=8, CNT_W=4) that shares the same stimulus.
module tb_df_process_profiler;
    import df_prof_pkg::*;

    logic clock;
    logic reset;
    logic enable, ap_start, ap_ready, ap_done, ap_continue, cin_stall, cout_stall;
    logic rdy, rdy_s;

    int n_checks = 0;
    int n_fail   = 0;
    int ts_exp   = 0;
    int t0;
    int ts_k [11];
    logic [23:0] exp_s;

    df_process_profiler_if #(.TS_W(32), .CNT_W(16)) bus ();
    df_process_profiler_if #(.TS_W(8),  .CNT_W(4))  bus_s ();

    assign bus.enable        = enable;
    assign bus.ap_start      = ap_start;
    assign bus.ap_ready      = ap_ready;
    assign bus.ap_done       = ap_done;
    assign bus.ap_continue   = ap_continue;
    assign bus.cin_stall     = cin_stall;
    assign bus.cout_stall    = cout_stall;
    assign bus.rec_ready     = rdy;
    assign bus_s.enable      = enable;
    assign bus_s.ap_start    = ap_start;
    assign bus_s.ap_ready    = ap_ready;
    assign bus_s.ap_done     = ap_done;
    assign bus_s.ap_continue = ap_continue;
    assign bus_s.cin_stall   = cin_stall;
    assign bus_s.cout_stall  = cout_stall;
    assign bus_s.rec_ready   = rdy_s;

    df_process_profiler #(.TS_W(32), .CNT_W(16), .DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    df_process_profiler #(.TS_W(8), .CNT_W(4), .DEPTH(8)) dut_s (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "timeout");
    end

    function automatic rec_t mk(input int ts, input int lat, input int cin, input int cout, input int blk);
        rec_t r;
        r.start_ts    = 32'(ts);
        r.latency     = 16'(lat);
        r.cin_cnt     = 16'(cin);
        r.cout_cnt    = 16'(cout);
        r.blocked_cnt = 16'(blk);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One clock; ts_exp tracks the timestamp value of the new current cycle.
    task automatic tick();
        logic r;
        r = reset;
        @(posedge clock);
        #1;
        ts_exp = r ? 0 : ts_exp + 1;
    endtask

    task automatic clear_hs();
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
        cin_stall = 0; cout_stall = 0;
    endtask

    initial begin
        reset = 1; enable = 0; rdy = 0; rdy_s = 1;
        clear_hs();
        repeat (3) tick();
        check("reset_busy",      128'(bus.busy),      128'(0));
        check("reset_valid",     128'(bus.rec_valid), 128'(0));
        check("reset_data",      128'(bus.rec_data),  128'(0));
        check("reset_start_cnt", 128'(bus.start_cnt), 128'(0));
        check("reset_drop_cnt",  128'(bus.drop_cnt),  128'(0));
        reset = 0; enable = 1;

        // Basic transaction: start at ts=5, done&continue at ts=9.
        repeat (5) tick();
        ap_start = 1; tick(); ap_start = 0;
        check("a_busy_run", 128'(bus.busy), 128'(1));
        repeat (3) tick();
        check("a_no_rec_before_done", 128'(bus.rec_valid), 128'(0));
        ap_done = 1; ap_continue = 1; ap_ready = 1; tick(); clear_hs();
        check("a_rec_valid", 128'(bus.rec_valid), 128'(1));
        check("a_rec_data",  128'(bus.rec_data),  128'(mk(5, 5, 0, 0, 0)));
        check("a_busy_idle", 128'(bus.busy),      128'(0));
        rdy = 1; tick(); rdy = 0;
        check("a_popped", 128'(bus.rec_valid), 128'(0));

        // Single-cycle transaction with a stall flag in the start cycle.
        t0 = ts_exp;
        ap_start = 1; ap_ready = 1; ap_done = 1; ap_continue = 1; cin_stall = 1;
        tick(); clear_hs();
        check("b_busy",      128'(bus.busy),      128'(0));
        check("b_rec_data",  128'(bus.rec_data),  128'(mk(t0, 1, 1, 0, 0)));
        check("b_start_cnt", 128'(bus.start_cnt), 128'(1));
        rdy = 1; tick(); rdy = 0;

        // Starts ignored while disabled, but still counted by start_cnt.
        enable = 0; ap_start = 1; ap_ready = 1; tick(); clear_hs(); enable = 1;
        check("dis_busy",      128'(bus.busy),      128'(0));
        check("dis_no_rec",    128'(bus.rec_valid), 128'(0));
        check("dis_start_cnt", 128'(bus.start_cnt), 128'(2));

        // Stalls + blocked; enable drops mid-transaction without aborting.
        t0 = ts_exp;
        ap_start = 1; tick(); ap_start = 0;
        for (int i = 0; i < 10; i++) begin
            cout_stall = (i < 4);
            cin_stall  = (i == 4 || i == 5);
            ap_done    = (i == 9);
            enable     = (i < 5);
            tick();
        end
        clear_hs();
        check("c_busy_blocked", 128'(bus.busy),      128'(1));
        check("c_no_rec_yet",   128'(bus.rec_valid), 128'(0));
        tick(); tick();
        ap_continue = 1; tick(); ap_continue = 0; enable = 1;
        check("c_rec_data", 128'(bus.rec_data), 128'(mk(t0, 14, 2, 4, 3)));
        check("c_busy",     128'(bus.busy),     128'(0));
        rdy = 1; tick(); rdy = 0;

        // Move the 8-bit timestamp of the narrow instance past its wrap.
        repeat (250) tick();

        // 40-cycle transaction with cin_stall held high throughout.
        rdy_s = 0;
        t0 = ts_exp;
        ap_start = 1; cin_stall = 1; tick(); ap_start = 0;
        repeat (38) tick();
        ap_done = 1; ap_continue = 1; tick(); clear_hs();
        check("d_rec_data_wide", 128'(bus.rec_data), 128'(mk(t0, 40, 40, 0, 0)));
        exp_s = {8'(t0), 4'hF, 4'hF, 4'h0, 4'h0};
        check("d_rec_data_sat", 128'(bus_s.rec_data), 128'(exp_s));
        rdy = 1; rdy_s = 1; tick(); rdy = 0;
        check("d_popped_wide", 128'(bus.rec_valid),   128'(0));
        check("d_popped_sat",  128'(bus_s.rec_valid), 128'(0));

        // Ten back-to-back records into the 8-deep FIFO with no consumer.
        for (int k = 0; k < 10; k++) begin
            ts_k[k] = ts_exp;
            ap_start = 1; ap_done = 1; ap_continue = 1; cout_stall = k[0];
            tick();
        end
        clear_hs();
        check("e_drop_cnt",  128'(bus.drop_cnt),  128'(2));
        check("e_rec_valid", 128'(bus.rec_valid), 128'(1));
        check("e_head",      128'(bus.rec_data),  128'(mk(ts_k[0], 1, 0, 0, 0)));
        tick();
        check("e_head_stable", 128'(bus.rec_data), 128'(mk(ts_k[0], 1, 0, 0, 0)));

        // Push and pop together while full: the push must be kept.
        rdy = 1;
        ts_k[10] = ts_exp;
        ap_start = 1; ap_done = 1; ap_continue = 1; tick(); clear_hs();
        check("e_drop_cnt_pushpop", 128'(bus.drop_cnt), 128'(2));
        for (int k = 1; k <= 8; k++) begin
            int idx;
            idx = (k == 8) ? 10 : k;
            check($sformatf("e_drain_%0d", k), 128'(bus.rec_data), 128'(mk(ts_k[idx], 1, 0, idx % 2, 0)));
            tick();
        end
        rdy = 0;
        check("e_drained", 128'(bus.rec_valid), 128'(0));

        // Reset during RUN discards the partial record.
        ap_start = 1; tick(); ap_start = 0; tick();
        check("f_busy_run", 128'(bus.busy), 128'(1));
        reset = 1; tick(); reset = 0;
        check("f_busy",      128'(bus.busy),      128'(0));
        check("f_no_rec",    128'(bus.rec_valid), 128'(0));
        check("f_start_cnt", 128'(bus.start_cnt), 128'(0));
        tick(); tick();
        ap_start = 1; tick(); ap_start = 0;
        ap_done = 1; ap_continue = 1; tick(); clear_hs();
        check("f_rec_valid", 128'(bus.rec_valid), 128'(1));
        check("f_rec_data",  128'(bus.rec_data),  128'(mk(2, 2, 0, 0, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
